// File: rtl/sc_regselect_sequencer_if.sv
// Request/selection bus for sc_regselect_sequencer.
//   master : request source / decoder side (drives valid, code, clearAll, stall)
//   slave  : the sequencer (drives ready, selection, busy, error)
interface sc_regselect_sequencer_if #(
  parameter int DATAWIDTH_SELECTION = 4
);
  logic                           SC_REGSEL_reqValid_In;
  logic [DATAWIDTH_SELECTION-1:0] SC_REGSEL_reqCode_InBUS;
  logic                           SC_REGSEL_reqReady_Out;
  logic                           SC_REGSEL_clearAll_In;
  logic                           SC_REGSEL_stall_In;
  logic [DATAWIDTH_SELECTION-1:0] SC_REGSEL_selection_OutBUS;
  logic                           SC_REGSEL_busy_Out;
  logic                           SC_REGSEL_error_Out;

  modport master (
    output SC_REGSEL_reqValid_In, SC_REGSEL_reqCode_InBUS,
           SC_REGSEL_clearAll_In, SC_REGSEL_stall_In,
    input  SC_REGSEL_reqReady_Out, SC_REGSEL_selection_OutBUS,
           SC_REGSEL_busy_Out, SC_REGSEL_error_Out
  );

  modport slave (
    input  SC_REGSEL_reqValid_In, SC_REGSEL_reqCode_InBUS,
           SC_REGSEL_clearAll_In, SC_REGSEL_stall_In,
    output SC_REGSEL_reqReady_Out, SC_REGSEL_selection_OutBUS,
           SC_REGSEL_busy_Out, SC_REGSEL_error_Out
  );
endinterface

// File: rtl/sc_regselect_sequencer.sv
// Register-selection code sequencer for the one-hot write-enable decoder.
// Buffers requested codes in a small FIFO and issues one per cycle on a
// registered output (0 = no register). A clear-all sweep drives 1..MAX_CODE.
// Ports:
//   SC_REGSEL_CLOCK_50    : clock, rising edge
//   SC_REGSEL_RESET_InLow : async active-low reset
//   bus (slave)           : request handshake, clearAll/stall controls,
//                           selection/busy/error outputs
module sc_regselect_sequencer #(
  parameter int DATAWIDTH_SELECTION = 4,
  parameter int FIFO_DEPTH          = 4,
  parameter int MAX_CODE            = 12
) (
  input  logic                    SC_REGSEL_CLOCK_50,
  input  logic                    SC_REGSEL_RESET_InLow,
  sc_regselect_sequencer_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef logic [DATAWIDTH_SELECTION-1:0] code_t;
  typedef enum logic {RUN, CLEAR} state_t;

  localparam code_t MAX_C = code_t'(MAX_CODE);

  state_t          state_q, state_d;
  code_t           cnt_q, cnt_d;     // sweep step to issue next
  code_t           sel_q, sel_d;
  logic            err_q, err_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  code_t           mem_q [FIFO_DEPTH];
  code_t           mem_d [FIFO_DEPTH];

  logic ready, accept, legal, push, pop;

  always_comb begin
    // Ready depends on registers only: no accept into a full FIFO even if
    // the head pops at the same edge.
    ready  = (state_q == RUN) && (count_q < CW'(FIFO_DEPTH));
    accept = bus.SC_REGSEL_reqValid_In & ready;
    legal  = (bus.SC_REGSEL_reqCode_InBUS != '0) &&
             (bus.SC_REGSEL_reqCode_InBUS <= MAX_C);
    push   = accept & legal;
    err_d  = accept & ~legal;

    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = '0;
    pop     = 1'b0;

    if (state_q == RUN) begin
      if (bus.SC_REGSEL_clearAll_In) begin
        state_d = CLEAR;
        cnt_d   = code_t'(1);
      end else if (!bus.SC_REGSEL_stall_In && count_q != '0) begin
        sel_d = mem_q[rd_ptr_q];
        pop   = 1'b1;
      end
    end else if (!bus.SC_REGSEL_stall_In) begin
      // CLEAR: clearAll ignored; stall just freezes the step counter.
      sel_d = cnt_q;
      if (cnt_q == MAX_C) begin
        state_d = RUN;
        cnt_d   = code_t'(1);
      end else begin
        cnt_d = cnt_q + code_t'(1);
      end
    end

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = bus.SC_REGSEL_reqCode_InBUS;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge SC_REGSEL_CLOCK_50 or negedge SC_REGSEL_RESET_InLow) begin
    if (!SC_REGSEL_RESET_InLow) begin
      state_q  <= RUN;
      cnt_q    <= code_t'(1);
      sel_q    <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.SC_REGSEL_reqReady_Out     = ready;
  assign bus.SC_REGSEL_selection_OutBUS = sel_q;
  assign bus.SC_REGSEL_error_Out        = err_q;
  assign bus.SC_REGSEL_busy_Out         = (state_q == CLEAR) || (count_q != '0);
endmodule
